imem_responder: RTL and testbench

Instruction-memory responder that serves the fetch stage's program-counter requests. It accepts one word-address request per cycle over a valid/ready handshake and reads a synchronous instruction RAM. It returns the instruction, tagged with its address, after a fixed pipeline latency through a skid/response queue. It also provides a backdoor write port for program loading and a flush input that discards in-flight fetches on a redirect.

---
 rtl/imem_responder.sv | 162 ++++++++++++++++
 tb/tb_imem_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready PC requests, synchronous RAM read,
// fixed-latency pipeline feeding a response FIFO with empty-queue bypass.
// Optional address fault checking is enabled by defining IMEM_ADDR_CHECK_EN.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned QDEPTH      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_instr,
    output logic        resp_err,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QD_FULL = CW'(QDEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0] mem [DEPTH_WORDS];

    logic [LATENCY-1:0] pv_q, pv_d;
    logic [31:0]        pa_q [LATENCY];
    logic [31:0]        pd_q [LATENCY];
    logic [LATENCY-1:0] pe_q;

    logic [31:0]       qa_q [QDEPTH];
    logic [31:0]       qi_q [QDEPTH];
    logic [QDEPTH-1:0] qe_q;
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]     qc_q, qc_d;
    logic [CW-1:0]     oc_q, oc_d;

    logic          req_err;
    logic [AW-1:0] rd_idx, wr_idx;
    logic          unused_wr_bits;
    logic          last_v, q_empty, resp_v, consume, ready_w, accept, push, pop;
    logic [31:0]   head_addr, head_data;
    logic          head_err;

    assign rd_idx         = req_addr[AW+1:2];
    assign wr_idx         = wr_addr[AW+1:2];
    assign unused_wr_bits = ^{wr_addr[31:AW+2], wr_addr[1:0]};

`ifdef IMEM_ADDR_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH_WORDS));
`else
    assign req_err = 1'b0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake: a consume frees a credit in the same cycle, so a full
    // responder can still accept while the head is being taken.
    always_comb begin
        last_v  = pv_q[LATENCY-1];
        q_empty = (qc_q == '0);
        resp_v  = !q_empty || last_v;
        consume = resp_v && resp_ready;
        ready_w = ((oc_q < QD_FULL) || consume) && !flush;
        accept  = req_valid && ready_w;
        push    = last_v && !(q_empty && resp_ready);
        pop     = !q_empty && resp_ready;
    end

    always_comb begin
        pv_d    = '0;
        pv_d[0] = accept;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
        end

        oc_d = oc_q;
        case ({accept, consume})
            2'b10:   oc_d = oc_q + CW'(1);
            2'b01:   oc_d = oc_q - CW'(1);
            default: oc_d = oc_q;
        endcase

        qc_d = qc_q;
        case ({push, pop})
            2'b10:   qc_d = qc_q + CW'(1);
            2'b01:   qc_d = qc_q - CW'(1);
            default: qc_d = qc_q;
        endcase

        wp_d = push ? ptr_inc(wp_q) : wp_q;
        rp_d = pop  ? ptr_inc(rp_q) : rp_q;

        if (flush) begin
            pv_d = '0;
            oc_d = '0;
            qc_d = '0;
            wp_d = '0;
            rp_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pv_q <= '0;
            oc_q <= '0;
            qc_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            pv_q <= pv_d;
            oc_q <= oc_d;
            qc_q <= qc_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Datapath storage is never reset; every consumer is qualified by a valid bit.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (accept) begin
            pd_q[0] <= mem[rd_idx];
        end
        pa_q[0] <= req_addr;
        pe_q[0] <= req_err;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pa_q[i] <= pa_q[i-1];
            pd_q[i] <= pd_q[i-1];
            pe_q[i] <= pe_q[i-1];
        end
        if (push) begin
            qa_q[wp_q] <= pa_q[LATENCY-1];
            qi_q[wp_q] <= pd_q[LATENCY-1];
            qe_q[wp_q] <= pe_q[LATENCY-1];
        end
    end

    always_comb begin
        head_addr = q_empty ? pa_q[LATENCY-1] : qa_q[rp_q];
        head_data = q_empty ? pd_q[LATENCY-1] : qi_q[rp_q];
        head_err  = q_empty ? pe_q[LATENCY-1] : qe_q[rp_q];

        req_ready  = ready_w;
        resp_valid = resp_v;
        resp_addr  = resp_v ? head_addr : '0;
        resp_instr = resp_v ? (head_err ? NOP_INSTR : head_data) : '0;
        resp_err   = resp_v && head_err;
    end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: predicted responses are queued on
// accept and compared on consume; directed phases cover latency, bursts, credits, flush, faults, reset.
module tb_imem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
    localparam int unsigned QD    = 4;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_addr, resp_instr;
    logic        resp_err;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;

    logic [31:0]  model [DEPTH];
    exp_t         sb [$];
    int unsigned  cons_cyc [$];
    int unsigned  cyc = 0;
    int unsigned  n_acc = 0;
    int unsigned  n_checks = 0;
    int unsigned  n_pass = 0;

    always #5 clock = ~clock;

    imem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .QDEPTH     (QD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_addr (resp_addr),
        .resp_instr(resp_instr),
        .resp_err  (resp_err),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic exp_t predict(input logic [31:0] a);
        exp_t        e;
        logic [AW-1:0] idx;
        idx     = a[AW+1:2];
        e.addr  = a;
        e.err   = 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
        e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
`endif
        e.instr = e.err ? NOP : model[idx];
        return e;
    endfunction

    // Monitor: consume before accept so a flush-cycle consume still sees the old head,
    // and predict before the backdoor write so same-cycle reads get old data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                sb.delete();
            end else begin
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        check("resp_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_addr", resp_addr, e.addr);
                        check("resp_instr", resp_instr, e.instr);
                        check("resp_err", resp_err, e.err);
                        cons_cyc.push_back(cyc);
                    end
                end
                if (flush) begin
                    sb.delete();
                end else if (req_valid && req_ready) begin
                    sb.push_back(predict(req_addr));
                    n_acc++;
                end
                if (wr_en) begin
                    model[wr_addr[AW+1:2]] = wr_data;
                end
            end
        end
    end

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] a);
        logic ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            ok = req_ready;
            @(posedge clock);
            #1;
            if (ok) break;
        end
        req_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        logic ok;
        ok         = 1'b0;
        resp_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (sb.size() == 0 && !resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        check("drain", ok, 1);
    endtask

    initial begin
        int unsigned n;
        int unsigned seen;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        int unsigned seen;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_addr", resp_addr, 0);
        check("rst_resp_instr", resp_instr, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            write_word(32'(4 * i), (i == 0) ? 32'h0010_0093 : $urandom());
        end

        // Latency of a single fetch
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (resp_valid) break;
            n++;
        end
        check("latency", n, LAT);
        check("first_instr", resp_instr, 32'h0010_0093);
        wait_drain();

        // Back-to-back burst: one response per cycle
        cons_cyc.delete();
        for (int i = 0; i < 8; i++) send(32'(4 * i));
        wait_drain();
        check("burst_count", cons_cyc.size(), 8);
        if (cons_cyc.size() >= 8) check("burst_no_gap", cons_cyc[7] - cons_cyc[0], 7);

        // Backpressure: credits run out at QDEPTH
        resp_ready = 1'b0;
        n_acc      = 0;
        req_valid  = 1'b1;
        for (int k = 0; k < int'(QD) + 3; k++) begin
            req_addr = 32'(4 * (k + 1));
            @(posedge clock);
            #1;
        end
        check("bp_accepts", n_acc, QD);
        @(negedge clock);
        check("bp_ready_low", req_ready, 0);
        check("bp_head_valid", resp_valid, 1);
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        req_addr   = 32'h24;
        @(negedge clock);
        check("bp_pulse_ready", req_ready, 1);
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        @(negedge clock);
        check("bp_ready_low_again", req_ready, 0);
        check("bp_accepts_after_pulse", n_acc, QD + 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        wait_drain();

        // Flush with requests in flight
        resp_ready = 1'b0;
        send(32'h4);
        send(32'h8);
        send(32'hC);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        @(negedge clock);
        check("flush_refuse", req_ready, 0);
        @(posedge clock);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        check("flush_ready_next", req_ready, 1);
        seen = 0;
        for (int k = 0; k < int'(LAT + QD); k++) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        check("flush_no_resp", seen, 0);
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        cons_cyc.delete();
        send(32'h24);
        wait_drain();
        check("flush_new_resp", cons_cyc.size(), 1);

        // Address fault / wrap behaviour
        cons_cyc.delete();
        send(32'h2);
        send(32'(4 * DEPTH));
        wait_drain();
        check("fault_resp_count", cons_cyc.size(), 2);

        // Backdoor write colliding with a read of the same word
        wr_en     = 1'b1;
        wr_addr   = 32'h14;
        wr_data   = 32'hCAFE_0001;
        req_valid = 1'b1;
        req_addr  = 32'h14;
        @(posedge clock);
        #1;
        wr_en     = 1'b0;
        req_valid = 1'b0;
        send(32'h14);
        wait_drain();

        // Reset with a full queue
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        for (int k = 0; k < int'(QD) + 2; k++) begin
            req_addr = 32'(4 * k);
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_resp_valid", resp_valid, 0);
        check("rst_mid_req_ready", req_ready, 1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        n_acc = 0;
        @(negedge clock);
        check("rst_release_idle", resp_valid, 0);
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        for (int k = 0; k < int'(QD) + 2; k++) begin
            req_addr = 32'(4 * k);
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        check("rst_count_cleared", n_acc, QD);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
